// File: rtl/dl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dl_pkg
// Description : Shared types, default sizes and ring-index helper for the
//               multi-channel sample delay line.
// Revision    : 1.0 - initial release
// ============================================================================
package dl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int c_data_w = 24;
    localparam int c_num_ch = 4;
    localparam int c_depth  = 23;

    // Slot holding the sample written d+1 writes before ptr, modulo depth.
    // Both ptr and d are below depth, so a single conditional add of depth
    // resolves the wrap without relying on power-of-two truncation.
    function automatic int unsigned wrap_index(input int unsigned ptr,
                                               input int unsigned d,
                                               input int unsigned depth);
        int unsigned back;
        back = d + 1;
        if (ptr >= back)
            return ptr - back;
        else
            return ptr + depth - back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_channel_mem.sv
`default_nettype none
// ============================================================================
// Module      : dl_channel_mem
// Description : One channel's ring memory: DEPTH x DATA_W storage with a
//               write port and a single registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_channel_mem
    import dl_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Sample storage; contents are intentionally left uninitialised by reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            r_mem[i_wr_idx] <= i_wr_data;
    end

    // Registered read; holds its last value between requests and sees
    // pre-write contents when reading and writing in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_rd_data <= '0;
        else if (i_rd_en)
            o_rd_data <= r_mem[i_rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/delay_line_bank.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_bank
// Description : Multi-channel sample delay line. Keeps the last DEPTH samples
//               per channel and returns, per channel, the sample written d
//               writes ago with one cycle of read latency.
//               Optional build macro DELAY_SUM_EN adds o_sum / o_sum_valid,
//               the registered sign-extended sum of all delayed samples.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_bank
    import dl_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int NUM_CH = c_num_ch,
    parameter int DEPTH  = c_depth,
    parameter int DLY_W  = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_clear,
    input  logic                     i_wr_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_wr_data,
    input  logic                     i_rd_req,
    input  logic [NUM_CH*DLY_W-1:0]  i_rd_delay,
    output logic                     o_ready,
    output logic                     o_rd_valid,
    output logic [NUM_CH*DATA_W-1:0] o_rd_data,
`ifdef DELAY_SUM_EN
    output logic [DATA_W+$clog2(NUM_CH)-1:0] o_sum,
    output logic                     o_sum_valid,
`endif
    output logic                     o_dly_err
);

    localparam int c_fill_w = $clog2(DEPTH + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DLY_W-1:0]    r_wr_ptr;
    logic [c_fill_w-1:0] r_fill_cnt;
    logic                r_rd_valid;
    logic                r_dly_err;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_fill_done;
    logic [NUM_CH-1:0]   w_oob;

    // The write that completes the buffer moves FILL to RUN.
    assign w_fill_done = w_wr_en && (r_fill_cnt == c_fill_w'(DEPTH - 1));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; a clear wins over everything else.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_state_nxt = S_FILL;
                S_FILL:  if (w_fill_done) w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State-decoded enables: writes in FILL/RUN, reads only in RUN.
    always_comb begin
        o_ready = 1'b0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            S_FILL: begin
                w_wr_en = i_wr_valid && !i_clear;
            end
            S_RUN: begin
                o_ready = 1'b1;
                w_wr_en = i_wr_valid && !i_clear;
                w_rd_en = i_rd_req && !i_clear;
            end
            default: ;
        endcase
    end

    // Write pointer wraps at DEPTH-1; fill count only advances while filling.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= (r_wr_ptr == DLY_W'(DEPTH - 1)) ? '0 : r_wr_ptr + DLY_W'(1);
            if (r_state == S_FILL)
                r_fill_cnt <= r_fill_cnt + c_fill_w'(1);
        end
    end

    // Per-channel clamp, index calculation and ring memory.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DLY_W-1:0] w_dly;
        logic [DLY_W-1:0] w_dly_clamped;
        logic [DLY_W-1:0] w_rd_idx;

        assign w_dly         = i_rd_delay[g*DLY_W +: DLY_W];
        assign w_oob[g]      = (32'(w_dly) >= DEPTH);
        assign w_dly_clamped = w_oob[g] ? DLY_W'(DEPTH - 1) : w_dly;
        assign w_rd_idx      = DLY_W'(wrap_index(32'(r_wr_ptr), 32'(w_dly_clamped), DEPTH));

        dl_channel_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (DLY_W)
        ) u_mem (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (w_wr_en),
            .i_wr_idx  (r_wr_ptr),
            .i_wr_data (i_wr_data[g*DATA_W +: DATA_W]),
            .i_rd_en   (w_rd_en),
            .i_rd_idx  (w_rd_idx),
            .o_rd_data (o_rd_data[g*DATA_W +: DATA_W])
        );
    end

    // Read-valid strobe and sticky out-of-range flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_dly_err  <= 1'b0;
        end else if (i_clear) begin
            r_rd_valid <= 1'b0;
            r_dly_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en && (|w_oob))
                r_dly_err <= 1'b1;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_dly_err  = r_dly_err;

`ifdef DELAY_SUM_EN
    localparam int c_sum_w = DATA_W + $clog2(NUM_CH);

    logic [c_sum_w-1:0] w_sum;

    // Sign-extend each delayed sample to the full sum width and accumulate.
    always_comb begin
        w_sum = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_sum = w_sum + c_sum_w'($signed(o_rd_data[c*DATA_W +: DATA_W]));
    end

    // Sum register trails the read data by one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sum       <= '0;
            o_sum_valid <= 1'b0;
        end else begin
            o_sum_valid <= r_rd_valid;
            if (r_rd_valid)
                o_sum <= w_sum;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/delay_line_bank.md
Name: delay_line_bank

Overview:
Multi-channel, parametrised sample delay line for the microphone-array beamformer. Stores the last DEPTH samples of each of NUM_CH audio channels in per-channel ring memories. Returns, per channel, the sample written d samples ago, with d supplied per channel on each read request. Sits between the I2S recorder front-end and the delay-and-sum pixel engine, all in the i_clk domain; the sample strobe comes from an upstream synchroniser.

Parameters:
DATA_W, 24, signed sample width
NUM_CH, 4, number of microphone channels
DEPTH, 23, samples retained per channel (any value >= 2, not necessarily a power of 2)
DLY_W, $clog2(DEPTH), width of each per-channel delay field

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  single-cycle pulse; leaves IDLE
i_clear  in  1  synchronous flush back to IDLE
i_wr_valid  in  1  one new sample per channel this cycle
i_wr_data  in  NUM_CH*DATA_W  packed samples, ch0 in LSBs
i_rd_req  in  1  read request
i_rd_delay  in  NUM_CH*DLY_W  packed per-channel delays
o_ready  out  1  buffer holds DEPTH valid samples (state RUN)
o_rd_valid  out  1  o_rd_data valid
o_rd_data  out  NUM_CH*DATA_W  delayed samples
o_dly_err  out  1  sticky: some requested delay was >= DEPTH

Behaviour:
- Reset: all outputs 0, state IDLE, write pointer 0, fill count 0, memories not cleared.
- States:
  - IDLE -> FILL on i_start.
  - FILL -> RUN when the DEPTH-th accepted write completes.
  - RUN stays in RUN.
  - i_clear from any state -> IDLE; clears pointer, fill count, o_dly_err, o_rd_valid. i_clear has priority over i_start and writes.
- Writes:
  - Accepted only in FILL/RUN when i_wr_valid=1; ignored in IDLE.
  - All channels are written at index wr_ptr.
  - wr_ptr increments and wraps DEPTH-1 -> 0. There is no full stall: RUN overwrites the oldest sample.
- Reads:
  - Serviced only in RUN. In IDLE/FILL, i_rd_req is ignored and o_rd_valid stays 0.
  - Fixed latency 1 cycle: o_rd_valid is high the cycle after i_rd_req, otherwise 0. o_rd_data holds its last value when not valid.
  - delay d=0 returns the newest accepted sample.
  - Read index = wr_ptr-1-d, modulo DEPTH. Wrap is computed by conditional add of DEPTH, not by truncation.
- Simultaneous write and read in the same cycle: the read sees pre-write contents, so d=0 returns the sample written before this cycle.
- Delay out of range (d >= DEPTH, only possible when DEPTH is not a power of 2):
  - d is clamped to DEPTH-1.
  - o_dly_err is set and stays set until reset or i_clear.
- Delays are evaluated independently per channel.

Optional Feature:
DELAY_SUM_EN
- Defined: adds port o_sum, out, DATA_W+$clog2(NUM_CH) bits.
  - o_sum is the sign-extended sum of all NUM_CH delayed samples.
  - It has one extra register stage: valid the cycle after o_rd_valid, flagged by added port o_sum_valid.
- Undefined: neither port exists; no adder logic.

Decomposition:
- Package dl_pkg:
  - state enum {S_IDLE, S_FILL, S_RUN}.
  - Default DATA_W/NUM_CH/DEPTH constants.
  - Function wrap_index(ptr, d, depth) for the modular read index.
- Sub-module dl_channel_mem, instantiated NUM_CH times by generate:
  - DEPTH x DATA_W array.
  - Write port plus one registered read port.
  - Read index is computed in the parent and shared by nothing; each channel gets its own index.

Test Plan:
- Fill and wrap: reset, i_start, write 23 samples ch0=1..23. o_ready rises after the 23rd write. Reads before that give o_rd_valid=0. Then read d=0 -> 23 and d=22 -> 1.
- Overwrite: continue with writes 24..30 (ptr wraps). d=0 -> 30, d=22 -> 8, d=6 -> 24.
- Per-channel delays and same-cycle write: channels 0..3 use delays 0, 5, 10, 22; each channel returns its distinct expected value. A read with a simultaneous write of 31 gives d=0 -> 30; the next read gives d=0 -> 31.
- Out-of-range delay: d=31 on ch2 returns the d=22 value and o_dly_err=1. The flag persists through further good reads and clears on i_clear.
- Clear/reset mid-run: i_clear during RUN gives o_ready=0 and o_rd_valid=0 next cycle, and reads are ignored until 23 new writes. An async i_rst mid-FILL zeros outputs immediately.
- DELAY_SUM_EN: samples ch0..3 = 100, -50, 7, -1 at the requested delays give o_sum=56 two cycles after i_rd_req. All four at -2^23 give o_sum=-2^25 with no overflow.
